dp_result_writer: RTL and testbench

AXI-style write initiator that stores each dot-product result into the byte-wide data memory.
- On DP_DONE it captures the 32-bit DP_RESULT and a destination address.
- It issues four single-byte write transactions (AW/W/B channels) to the memory, little-endian.
- It sits between dot_product_accelerator and memory, alongside axi_master, which drives the memory read side.

---
 rtl/dp_axi_pkg.sv | 28 ++
 rtl/dp_wr_channel.sv | 82 ++++++++
 rtl/dp_result_writer.sv | 198 +++++++++++++++++++
 tb/tb_dp_result_writer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dp_axi_pkg.sv
// -----------------------------------------------------------------------------
// dp_axi_pkg
// Shared definitions for the dot-product result writer: writer FSM state
// encoding, the number of bytes per result, the default per-phase timeout and
// a helper that picks one little-endian byte out of a 32-bit result.
// No ports (package).
// -----------------------------------------------------------------------------
package dp_axi_pkg;

    // Writer FSM states. IDLE is encoded as zero so a cleared state register
    // and a cleared debug output read the same.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_RESP = 2'd2
    } wr_state_t;

    localparam int BYTES_PER_RESULT    = 4;
    localparam int IDX_W               = 2;
    localparam int TIMEOUT_CYC_DEFAULT = 256;

    // Byte idx of a 32-bit result, byte 0 being bits [7:0] (little-endian).
    function automatic logic [7:0] result_byte(input logic [31:0]      res,
                                               input logic [IDX_W-1:0] idx);
        return res[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/dp_wr_channel.sv
// -----------------------------------------------------------------------------
// dp_wr_channel
// Issues one single-byte write on the AW and W channels. Both valids rise
// together on start; each channel completes on its own handshake and its
// valid drops the cycle after. both_done tells the owner that both
// handshakes have happened (possibly this very cycle).
//
// Handshake rule (all channels): a transfer happens on a rising clock edge
// where VALID and READY are both 1. Once VALID is raised it stays high, with
// its payload unchanged, until that edge; READY may toggle freely.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             load start_addr/start_data and raise both valids
//   abort             drop both valids immediately (timeout abort)
//   start_addr/data   address and byte for the next write
//   awaddr/awvalid/awready   AW channel
//   wdata/wvalid/wready      W channel
//   both_done         AW and W handshakes are both complete
// -----------------------------------------------------------------------------
module dp_wr_channel #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [7:0]        start_data,
    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [7:0]        wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              both_done
);

    logic aw_done_q;
    logic w_done_q;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;

    // Either channel may have finished in an earlier cycle or finish now.
    assign both_done = (aw_done_q | aw_hs) & (w_done_q | w_hs);

    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wvalid    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (abort) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (start) begin
            awaddr    <= start_addr;
            wdata     <= start_data;
            awvalid   <= 1'b1;
            wvalid    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                awvalid   <= 1'b0;
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                wvalid   <= 1'b0;
                w_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dp_result_writer.sv
// -----------------------------------------------------------------------------
// dp_result_writer
// Captures a 32-bit dot-product result and destination address on DP_DONE
// and writes it to byte-wide memory as four single-byte AW/W/B transactions,
// byte 0 (bits [7:0]) at DST_ADDR, byte n at DST_ADDR+n (address wraps).
//
// Handshake rule (all channels): a transfer happens on a rising clock edge
// where VALID and READY are both 1. Once VALID is raised it stays high, with
// its payload unchanged, until that edge; READY may toggle freely.
//
// Ports:
//   ACLK, ARESET      clock, synchronous active-high reset
//   DP_RESULT/DP_DONE/DST_ADDR   result, strobe and byte-0 address
//   CLR_FLAGS         clears OVERRUN and ERR (a same-cycle set wins)
//   MEM_AW*/MEM_W*/MEM_B*        memory write channels
//   WR_BUSY           any state other than IDLE
//   WR_DONE           one-cycle pulse after the 4th write response
//   OVERRUN           sticky: DP_DONE arrived while busy, result dropped
//   ERR               sticky: a phase timed out and the write was aborted
//   dbg_state         current FSM state
// -----------------------------------------------------------------------------
module dp_result_writer
    import dp_axi_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [31:0]       DP_RESULT,
    input  logic              DP_DONE,
    input  logic [ADDR_W-1:0] DST_ADDR,
    input  logic              CLR_FLAGS,
    output logic [ADDR_W-1:0] MEM_AWADDR,
    output logic              MEM_AWVALID,
    input  logic              MEM_AWREADY,
    output logic [7:0]        MEM_WDATA,
    output logic              MEM_WVALID,
    input  logic              MEM_WREADY,
    input  logic              MEM_BVALID,
    output logic              MEM_BREADY,
    output logic              WR_BUSY,
    output logic              WR_DONE,
    output logic              OVERRUN,
    output logic              ERR,
    output wr_state_t         dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_RESULT - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

    wr_state_t         state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       res_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              bready_q;
    logic              wr_done_q;
    logic              overrun_q;
    logic              err_q;

    logic              both_done;
    logic              accept;
    logic              b_hs;
    logic              last_byte;
    logic              phase_expired;
    logic              abort;
    logic              start;
    logic [31:0]       start_res;
    logic [ADDR_W-1:0] start_base;
    logic [IDX_W-1:0]  start_idx;
    logic [ADDR_W-1:0] start_addr;
    logic [7:0]        start_data;

    always_comb begin
        accept        = (state_q == ST_IDLE) && DP_DONE;
        b_hs          = (state_q == ST_RESP) && MEM_BVALID && bready_q;
        last_byte     = (idx_q == IDX_LAST);
        // cnt_q counts cycles already spent in this phase; the phase may use
        // TIMEOUT_CYC cycles and is aborted at the end of the last one unless
        // it made progress in that cycle.
        phase_expired = (cnt_q == CNT_LIMIT);
        abort         = phase_expired &&
                        (((state_q == ST_SEND) && !both_done) ||
                         ((state_q == ST_RESP) && !b_hs));
        start         = accept || (b_hs && !last_byte);

        // On capture the registers are not loaded yet, so the first byte is
        // taken straight from the inputs.
        start_res     = accept ? DP_RESULT : res_q;
        start_base    = accept ? DST_ADDR : base_q;
        start_idx     = accept ? '0 : idx_q + IDX_W'(1);
        start_addr    = start_base + ADDR_W'(start_idx);
        start_data    = result_byte(start_res, start_idx);
    end

    dp_wr_channel #(
        .ADDR_W (ADDR_W)
    ) u_channel (
        .clk        (ACLK),
        .rst        (ARESET),
        .start      (start),
        .abort      (abort),
        .start_addr (start_addr),
        .start_data (start_data),
        .awaddr     (MEM_AWADDR),
        .awvalid    (MEM_AWVALID),
        .awready    (MEM_AWREADY),
        .wdata      (MEM_WDATA),
        .wvalid     (MEM_WVALID),
        .wready     (MEM_WREADY),
        .both_done  (both_done)
    );

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            res_q     <= '0;
            base_q    <= '0;
            cnt_q     <= '0;
            bready_q  <= 1'b0;
            wr_done_q <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            cnt_q     <= (state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        res_q   <= DP_RESULT;
                        base_q  <= DST_ADDR;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (both_done) begin
                        bready_q <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= ST_RESP;
                    end else if (phase_expired) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_RESP: begin
                    if (b_hs) begin
                        bready_q <= 1'b0;
                        cnt_q    <= '0;
                        if (last_byte) begin
                            wr_done_q <= 1'b1;
                            state_q   <= ST_IDLE;
                        end else begin
                            idx_q   <= idx_q + IDX_W'(1);
                            state_q <= ST_SEND;
                        end
                    end else if (phase_expired) begin
                        bready_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= ST_IDLE;
                    end
                end
                default: begin
                    bready_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= ST_IDLE;
                end
            endcase

            // Any DP_DONE outside IDLE is dropped, including the cycle the
            // FSM is returning to IDLE. Set has priority over clear.
            if (DP_DONE && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end else if (CLR_FLAGS) begin
                overrun_q <= 1'b0;
            end

            if (abort) begin
                err_q <= 1'b1;
            end else if (CLR_FLAGS) begin
                err_q <= 1'b0;
            end
        end
    end

    assign MEM_BREADY = bready_q;
    assign WR_BUSY    = (state_q != ST_IDLE);
    assign WR_DONE    = wr_done_q;
    assign OVERRUN    = overrun_q;
    assign ERR        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dp_result_writer.sv
// -----------------------------------------------------------------------------
// tb_dp_result_writer
// Directed bench for dp_result_writer (TIMEOUT_CYC = 8). A byte-wide memory
// responder with per-channel ready/response delays answers the write
// channels at the falling edge; the test sequence drives inputs and samples
// outputs 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_dp_result_writer;
    import dp_axi_pkg::*;

    localparam int ADDR_W = 32;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [31:0]       DP_RESULT;
    logic              DP_DONE;
    logic [ADDR_W-1:0] DST_ADDR;
    logic              CLR_FLAGS;
    logic [ADDR_W-1:0] MEM_AWADDR;
    logic              MEM_AWVALID;
    logic              MEM_AWREADY;
    logic [7:0]        MEM_WDATA;
    logic              MEM_WVALID;
    logic              MEM_WREADY;
    logic              MEM_BVALID;
    logic              MEM_BREADY;
    logic              WR_BUSY;
    logic              WR_DONE;
    logic              OVERRUN;
    logic              ERR;
    wr_state_t         dbg_state;

    dp_result_writer #(
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (8)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .DP_RESULT   (DP_RESULT),
        .DP_DONE     (DP_DONE),
        .DST_ADDR    (DST_ADDR),
        .CLR_FLAGS   (CLR_FLAGS),
        .MEM_AWADDR  (MEM_AWADDR),
        .MEM_AWVALID (MEM_AWVALID),
        .MEM_AWREADY (MEM_AWREADY),
        .MEM_WDATA   (MEM_WDATA),
        .MEM_WVALID  (MEM_WVALID),
        .MEM_WREADY  (MEM_WREADY),
        .MEM_BVALID  (MEM_BVALID),
        .MEM_BREADY  (MEM_BREADY),
        .WR_BUSY     (WR_BUSY),
        .WR_DONE     (WR_DONE),
        .OVERRUN     (OVERRUN),
        .ERR         (ERR),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 ACLK = ~ACLK;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- memory responder + monitors ----------------
    logic [7:0]        mem [logic [31:0]];
    logic [ADDR_W-1:0] aw_q [$];
    logic [7:0]        w_q [$];
    int aw_delay = 0, w_delay = 0, b_delay = 0;
    bit b_en = 1'b1;
    int aw_wait, w_wait, b_wait, b_owed;
    bit b_hs_pend;
    bit aw_stall_prev, w_stall_prev;
    logic [ADDR_W-1:0] aw_addr_prev;
    logic [7:0]        w_data_prev;
    int stab_err = 0;
    int proto_err = 0;
    int done_cnt = 0;

    initial begin : mem_model
        MEM_AWREADY = 1'b0;
        MEM_WREADY  = 1'b0;
        MEM_BVALID  = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0; b_owed = 0; b_hs_pend = 1'b0;
        aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
        aw_addr_prev = '0; w_data_prev = '0;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                aw_q.delete();
                w_q.delete();
                MEM_AWREADY = 1'b0;
                MEM_WREADY  = 1'b0;
                MEM_BVALID  = 1'b0;
                aw_wait = 0; w_wait = 0; b_wait = 0; b_owed = 0; b_hs_pend = 1'b0;
                aw_stall_prev = 1'b0; w_stall_prev = 1'b0;
            end else begin
                // B first, so a write paired below is answered no earlier
                // than the cycle after its handshake edge.
                if (b_hs_pend) begin
                    b_owed--;
                    MEM_BVALID = 1'b0;
                    b_wait = 0;
                    b_hs_pend = 1'b0;
                end
                if (!b_en) begin
                    b_owed = 0;
                    MEM_BVALID = 1'b0;
                    b_wait = 0;
                end else if (b_owed > 0 && !MEM_BVALID) begin
                    if (b_wait >= b_delay) begin
                        MEM_BVALID = 1'b1;
                        b_wait = 0;
                    end else begin
                        b_wait++;
                    end
                end
                if (MEM_BVALID && MEM_BREADY) b_hs_pend = 1'b1;

                if (MEM_AWVALID) begin
                    if (aw_wait >= aw_delay) begin
                        MEM_AWREADY = 1'b1;
                        aw_q.push_back(MEM_AWADDR);
                        aw_wait = 0;
                    end else begin
                        MEM_AWREADY = 1'b0;
                        aw_wait++;
                    end
                end else begin
                    MEM_AWREADY = 1'b0;
                    aw_wait = 0;
                end

                if (MEM_WVALID) begin
                    if (w_wait >= w_delay) begin
                        MEM_WREADY = 1'b1;
                        w_q.push_back(MEM_WDATA);
                        w_wait = 0;
                    end else begin
                        MEM_WREADY = 1'b0;
                        w_wait++;
                    end
                end else begin
                    MEM_WREADY = 1'b0;
                    w_wait = 0;
                end

                while (aw_q.size() > 0 && w_q.size() > 0) begin
                    mem[aw_q.pop_front()] = w_q.pop_front();
                    b_owed++;
                end

                // A stalled valid must stay high with an unchanged payload.
                if (aw_stall_prev && (!MEM_AWVALID || MEM_AWADDR != aw_addr_prev)) stab_err++;
                if (w_stall_prev && (!MEM_WVALID || MEM_WDATA != w_data_prev)) stab_err++;
                aw_stall_prev = MEM_AWVALID && !MEM_AWREADY;
                w_stall_prev  = MEM_WVALID && !MEM_WREADY;
                aw_addr_prev  = MEM_AWADDR;
                w_data_prev   = MEM_WDATA;

                if (MEM_BREADY && (MEM_AWVALID || MEM_WVALID)) proto_err++;
                if (WR_DONE) done_cnt++;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    task automatic check_mem(input string tag, input logic [31:0] base, input logic [31:0] res);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = base + 32'(i);
            check_eq(tag, {24'h0, mem_rd(a)}, {24'h0, res[8*i +: 8]});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pulse(input logic [31:0] res, input logic [31:0] addr);
        DP_RESULT = res;
        DST_ADDR  = addr;
        DP_DONE   = 1'b1;
        tick();
        DP_DONE   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (WR_DONE !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, WR_DONE, 1'b1);
        tick();
    endtask

    // ---------------- test sequence ----------------
    int done_ref;

    initial begin : main
        ARESET    = 1'b1;
        DP_DONE   = 1'b0;
        DP_RESULT = '0;
        DST_ADDR  = '0;
        CLR_FLAGS = 1'b0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_awvalid", MEM_AWVALID, 1'b0);
        check_eq("rst_wvalid",  MEM_WVALID, 1'b0);
        check_eq("rst_bready",  MEM_BREADY, 1'b0);
        check_eq("rst_busy",    WR_BUSY, 1'b0);
        check_eq("rst_flags",   {WR_DONE, OVERRUN, ERR}, 3'b000);
        check_eq("rst_awaddr",  MEM_AWADDR, 32'h0);
        ARESET = 1'b0;
        tick();

        // Happy path: cycle T is the DP_DONE cycle; pulse returns in T+1.
        pulse(32'hDEAD_BEEF, 32'h100);
        check_eq("hp_awaddr0", MEM_AWADDR, 32'h100);
        check_eq("hp_wdata0",  MEM_WDATA, 8'hEF);
        for (int k = 1; k <= 8; k++) begin
            check_eq("hp_busy",  WR_BUSY, 1'b1);
            check_eq("hp_state", dbg_state, (k % 2 == 1) ? ST_SEND : ST_RESP);
            check_eq("hp_done_early", WR_DONE, 1'b0);
            tick();
        end
        check_eq("hp_done_t9", WR_DONE, 1'b1);
        check_eq("hp_idle_t9", WR_BUSY, 1'b0);
        tick();
        check_eq("hp_done_pulse", WR_DONE, 1'b0);
        check_mem("hp_mem", 32'h100, 32'hDEAD_BEEF);
        check_eq("hp_byte3", {24'h0, mem_rd(32'h103)}, 32'hDE);
        check_eq("hp_done_cnt", done_cnt, 1);

        // Skewed handshakes
        aw_delay = 3; w_delay = 0; b_delay = 2;
        pulse(32'hCAFE_F00D, 32'h200);
        check_eq("sk_both_valid", {MEM_AWVALID, MEM_WVALID}, 2'b11);
        check_eq("sk_wdata", MEM_WDATA, 8'h0D);
        tick();
        check_eq("sk_w_drops_alone", {MEM_AWVALID, MEM_WVALID}, 2'b10);
        check_eq("sk_awaddr_hold", MEM_AWADDR, 32'h200);
        check_eq("sk_no_resp", MEM_BREADY, 1'b0);
        wait_done(100, "sk_done");
        check_mem("sk_mem", 32'h200, 32'hCAFE_F00D);
        check_eq("sk_stable", stab_err, 0);
        check_eq("sk_proto", proto_err, 0);
        aw_delay = 0; b_delay = 0;

        // Overrun; the dropped DP_DONE comes with CLR_FLAGS (set wins)
        pulse(32'hA1B2_C3D4, 32'h300);
        tick();
        CLR_FLAGS = 1'b1;
        pulse(32'h1111_2222, 32'h380);
        CLR_FLAGS = 1'b0;
        check_eq("ov_set", OVERRUN, 1'b1);
        wait_done(40, "ov_done");
        check_mem("ov_mem", 32'h300, 32'hA1B2_C3D4);
        check_eq("ov_dropped", mem.exists(32'h380), 1'b0);
        check_eq("ov_sticky", OVERRUN, 1'b1);
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        check_eq("ov_clr", OVERRUN, 1'b0);

        // Timeout in RESP: first RESP cycle is T+2, abort visible at T+10
        done_ref = done_cnt;
        b_en = 1'b0;
        pulse(32'h5566_7788, 32'h400);
        tick();
        check_eq("to_resp", dbg_state, ST_RESP);
        repeat (7) tick();
        check_eq("to_last_cycle", {MEM_BREADY, ERR}, 2'b10);
        check_eq("to_still_resp", dbg_state, ST_RESP);
        tick();
        check_eq("to_err", ERR, 1'b1);
        check_eq("to_bready", MEM_BREADY, 1'b0);
        check_eq("to_idle", dbg_state, ST_IDLE);
        check_eq("to_no_done", done_cnt, done_ref);
        b_en = 1'b1;
        CLR_FLAGS = 1'b1;
        tick();
        CLR_FLAGS = 1'b0;
        check_eq("to_err_clr", ERR, 1'b0);
        pulse(32'h5566_7788, 32'h480);
        wait_done(40, "to_retry_done");
        check_mem("to_retry_mem", 32'h480, 32'h5566_7788);

        // Address wrap
        pulse(32'h0403_0201, 32'hFFFF_FFFE);
        wait_done(40, "wr_done");
        check_eq("wrap_fffe", {24'h0, mem_rd(32'hFFFF_FFFE)}, 32'h01);
        check_eq("wrap_ffff", {24'h0, mem_rd(32'hFFFF_FFFF)}, 32'h02);
        check_eq("wrap_0000", {24'h0, mem_rd(32'h0000_0000)}, 32'h03);
        check_eq("wrap_0001", {24'h0, mem_rd(32'h0000_0001)}, 32'h04);

        // Reset during byte 2 SEND (cycle T+5)
        done_ref = done_cnt;
        pulse(32'h9988_7766, 32'h500);
        repeat (4) tick();
        check_eq("mr_send2", dbg_state, ST_SEND);
        check_eq("mr_addr2", MEM_AWADDR, 32'h502);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        check_eq("mr_valids", {MEM_AWVALID, MEM_WVALID, MEM_BREADY}, 3'b000);
        check_eq("mr_status", {WR_BUSY, WR_DONE, OVERRUN, ERR}, 4'b0000);
        check_eq("mr_payload", {MEM_AWADDR, 24'h0, MEM_WDATA}, 64'h0);
        repeat (3) tick();
        check_eq("mr_no_done", done_cnt, done_ref);
        check_eq("mr_no_byte2", mem.exists(32'h502), 1'b0);
        pulse(32'h1234_5678, 32'h600);
        wait_done(40, "mr_fresh_done");
        check_mem("mr_fresh_mem", 32'h600, 32'h1234_5678);

        check_eq("final_stable", stab_err, 0);
        check_eq("final_proto", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
